quad_encoder_gen: RTL and testbench



---
 rtl/quad_encoder_gen.sv | 112 +++++++++++
 tb/tb_quad_encoder_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: integrates a signed rate into A/B/Z waveforms with minimum edge spacing.
// Optional index output is enabled by defining ENCGEN_INDEX_EN; otherwise enc_z is tied low.
module quad_encoder_gen #(
  parameter int ACC_WIDTH = 32,
  parameter int CPR       = 2048,
  parameter int MIN_EDGE  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] rate,
  input  logic                 pos_load,
  input  logic [31:0]          pos_value,
  input  logic                 overrun_clr,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 enc_z,
  output logic [31:0]          position,
  output logic [3:0]           pending,
  output logic                 overrun
);

  localparam int              GAP_W      = (MIN_EDGE > 1) ? $clog2(MIN_EDGE) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_EDGE - 1);
  localparam logic [31:0]     POS_MAX    = 32'(CPR - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic                 req_fwd;
  logic                 req_rev;
  logic signed [3:0]    pend_q;
  logic [GAP_W-1:0]     gap;

  logic                 emit;
  logic                 emit_fwd;
  logic                 emit_rev;
  logic                 drop;
  logic [4:0]           pend_sum;
  logic [3:0]           pend_next;
  logic [GAP_W-1:0]     gap_next;
  logic [31:0]          pos_next;
  logic                 overrun_next;

  // The sign-extended add at ACC_WIDTH+1 bits exposes carry (rate>0) and borrow (rate<0) in the top bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    sum     = {1'b0, acc} + {rate[ACC_WIDTH-1], rate};
    req_fwd = enable && sum[ACC_WIDTH] && !rate[ACC_WIDTH-1];
    req_rev = enable && sum[ACC_WIDTH] &&  rate[ACC_WIDTH-1];

    emit     = (gap == '0) && (pend_q != 4'sd0);
    emit_fwd = emit && !pend_q[3];
    emit_rev = emit &&  pend_q[3];

    // A same-direction request into a full queue is lost unless a step drains it this cycle.
    drop = !emit && ((req_fwd && pend_q == 4'sd7) || (req_rev && pend_q == -4'sd7));

    pend_sum = {pend_q[3], pend_q}
             + (req_fwd  ? 5'd1 : 5'd0) - (req_rev  ? 5'd1 : 5'd0)
             - (emit_fwd ? 5'd1 : 5'd0) + (emit_rev ? 5'd1 : 5'd0);

    pend_next = drop ? pend_q : pend_sum[3:0];
    gap_next  = emit ? GAP_RELOAD : ((gap != '0) ? gap - 1'b1 : '0);
    pos_next  = position;
    if (emit_fwd) pos_next = (position == POS_MAX) ? 32'd0 : position + 32'd1;
    if (emit_rev) pos_next = (position == 32'd0) ? POS_MAX : position - 32'd1;
    overrun_next = overrun;

    // Load overrides any step or request in the same cycle.
    if (pos_load) begin
      pend_next = 4'd0;
      gap_next  = GAP_RELOAD;
      pos_next  = pos_value;
    end

    if (drop && !pos_load) overrun_next = 1'b1;
    else if (overrun_clr)  overrun_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset) begin
      acc      <= '0;
      pend_q   <= '0;
      gap      <= '0;
      position <= '0;
      enc_a    <= 1'b0;
      enc_b    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (enable) acc <= sum[ACC_WIDTH-1:0];
      pend_q   <= pend_next;
      gap      <= gap_next;
      position <= pos_next;
      enc_a    <= pos_next[1] ^ pos_next[0];
      enc_b    <= pos_next[1];
      overrun  <= overrun_next;
    end
  end

`ifdef ENCGEN_INDEX_EN
  always_ff @(posedge clk) begin
    if (reset) enc_z <= 1'b1;
    else       enc_z <= (pos_next == 32'd0);
  end
`else
  assign enc_z = 1'b0;
`endif

  assign pending = pend_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: vector table, directed corner sequences, and a
// randomized run compared every cycle against an arithmetic reference model.
module tb_quad_encoder_gen;

  localparam int W        = 32;
  localparam int CPR      = 2048;
  localparam int MIN_EDGE = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  rate = '0;
  logic          pos_load = 1'b0;
  logic [31:0]   pos_value = '0;
  logic          overrun_clr = 1'b0;
  logic          enc_a, enc_b, enc_z;
  logic [31:0]   position;
  logic [3:0]    pending;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  longint m_acc;
  int     m_pend, m_gap, m_pos;
  bit     m_ovr;

  quad_encoder_gen #(.ACC_WIDTH(W), .CPR(CPR), .MIN_EDGE(MIN_EDGE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate(rate),
    .pos_load(pos_load), .pos_value(pos_value), .overrun_clr(overrun_clr),
    .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .position(position), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_z(input int p);
`ifdef ENCGEN_INDEX_EN
    return (p == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_a(input int p);
    return (p % 4 == 1) || (p % 4 == 2);
  endfunction

  function automatic bit exp_b(input int p);
    return (p % 4 == 2) || (p % 4 == 3);
  endfunction

  // One clock of the specified behaviour, expressed with integer arithmetic.
  task automatic model_step();
    longint s;
    int req, dir;
    bit drop;
    if (reset) begin
      m_acc = 0; m_pend = 0; m_gap = 0; m_pos = 0; m_ovr = 0;
      return;
    end
    req = 0;
    if (enable) begin
      s = m_acc + longint'($signed(rate));
      if (s >= 64'sd4294967296)  begin req = 1;  s = s - 64'sd4294967296; end
      else if (s < 0)            begin req = -1; s = s + 64'sd4294967296; end
      m_acc = s;
    end
    drop = 0;
    if (pos_load) begin
      m_pos  = int'(pos_value);
      m_pend = 0;
      m_gap  = MIN_EDGE - 1;
    end else begin
      dir = (m_gap == 0 && m_pend != 0) ? ((m_pend > 0) ? 1 : -1) : 0;
      m_gap = (dir != 0) ? MIN_EDGE - 1 : ((m_gap > 0) ? m_gap - 1 : 0);
      drop = (req != 0) && (dir == 0) && (m_pend == 7 * req);
      if (!drop) m_pend = m_pend + req - dir;
      else       m_pend = m_pend - dir;
      m_pos = (m_pos + dir + CPR) % CPR;
    end
    if (drop)             m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
  endtask

  task automatic check_all();
    check("model_position", position, m_pos);
    check("model_enc_a", enc_a, exp_a(m_pos));
    check("model_enc_b", enc_b, exp_b(m_pos));
    check("model_enc_z", enc_z, exp_z(m_pos));
    check("model_pending", $signed(pending), m_pend);
    check("model_overrun", overrun, m_ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; rate = '0; pos_load = 1'b0; overrun_clr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] rate;
    int           n;
    int           pos;
    bit           a;
    bit           b;
    int           pend;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int t, last_edge, edges, k;
    bit seen;
    logic [1:0] ab_prev;
    logic [31:0] pos_prev;

    vecs[0] = '{32'h1000_0000, 16, 0,    1'b0, 1'b0,  1};
    vecs[1] = '{32'h1000_0000, 17, 1,    1'b1, 1'b0,  0};
    vecs[2] = '{32'h1000_0000, 33, 2,    1'b1, 1'b1,  0};
    vecs[3] = '{32'h1000_0000, 49, 3,    1'b0, 1'b1,  0};
    vecs[4] = '{32'h1000_0000, 65, 4,    1'b0, 1'b0,  0};
    vecs[5] = '{32'hF000_0000, 1,  0,    1'b0, 1'b0, -1};
    vecs[6] = '{32'hF000_0000, 2,  2047, 1'b0, 1'b1,  0};
    vecs[7] = '{32'hF000_0000, 18, 2046, 1'b1, 1'b1,  0};
    vecs[8] = '{32'h0000_0000, 20, 0,    1'b0, 1'b0,  0};
    vecs[9] = '{32'h4000_0000, 9,  2,    1'b1, 1'b1,  0};

    // Reset state
    do_reset();
    check("reset_position", position, 0);
    check("reset_ab", {enc_a, enc_b}, 0);
    check("reset_z", enc_z, exp_z(0));
    check("reset_pending", pending, 0);
    check("reset_overrun", overrun, 0);

    // Vector table: run from reset at a fixed rate for n clocks
    for (int i = 0; i < 10; i++) begin
      do_reset();
      rate = vecs[i].rate; enable = 1'b1;
      repeat (vecs[i].n) tick();
      enable = 1'b0;
      check($sformatf("vec%0d_position", i), position, vecs[i].pos);
      check($sformatf("vec%0d_enc_a", i), enc_a, vecs[i].a);
      check($sformatf("vec%0d_enc_b", i), enc_b, vecs[i].b);
      check($sformatf("vec%0d_enc_z", i), enc_z, exp_z(vecs[i].pos));
      check($sformatf("vec%0d_pending", i), $signed(pending), vecs[i].pend);
    end

    // Maximum rate: edges paced at MIN_EDGE, queue saturates, overrun sets and re-sets after clear
    do_reset();
    rate = 32'h7FFF_FFFF; enable = 1'b1;
    t = 0; seen = 0; last_edge = -1; ab_prev = {enc_a, enc_b};
    while (!seen && t < 40) begin
      tick(); t++;
      if ({enc_a, enc_b} != ab_prev) begin
        if (last_edge >= 0) check("max_rate_edge_spacing", t - last_edge, MIN_EDGE);
        last_edge = t;
        ab_prev = {enc_a, enc_b};
      end
      if (overrun) seen = 1;
    end
    check("overrun_within_40", seen, 1);
    check("pending_saturated", $signed(pending), 7);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (overrun) seen = 1;
    end
    check("overrun_reasserts", seen, 1);

    // Load with queued steps: queue flushed, gap enforced, then forward steps through the index
    do_reset();
    rate = 32'h7FFF_FFFF; enable = 1'b1;
    t = 0;
    while ($signed(pending) != 3 && t < 40) begin tick(); t++; end
    check("reach_pending_3", $signed(pending), 3);
    enable = 1'b0; pos_load = 1'b1; pos_value = 32'd2046;
    tick();
    pos_load = 1'b0;
    check("load_position", position, 2046);
    check("load_ab", {enc_a, enc_b}, 2'b11);
    check("load_pending", pending, 0);
    check("load_z", enc_z, 0);
    enable = 1'b1;
    k = 0; pos_prev = position;
    while (position == pos_prev && k < 40) begin tick(); k++; end
    check("load_to_edge_at_least_min_edge", (k >= MIN_EDGE), 1);
    check("after_load_pos_2047", position, 2047);
    check("after_load_ab_01", {enc_a, enc_b}, 2'b01);
    k = 0; pos_prev = position;
    while (position == pos_prev && k < 40) begin tick(); k++; end
    check("wrap_pos_0", position, 0);
    check("wrap_ab_00", {enc_a, enc_b}, 2'b00);
    check("wrap_z", enc_z, exp_z(0));

    // Drain after enable drops: exactly the queued steps, spaced MIN_EDGE
    do_reset();
    rate = 32'h7FFF_FFFF; enable = 1'b1;
    t = 0;
    while ($signed(pending) != 2 && t < 40) begin tick(); t++; end
    check("reach_pending_2", $signed(pending), 2);
    enable = 1'b0;
    edges = 0; last_edge = -1; ab_prev = {enc_a, enc_b};
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ({enc_a, enc_b} != ab_prev) begin
        if (last_edge >= 0) check("drain_edge_spacing", i - last_edge, MIN_EDGE);
        last_edge = i; edges++;
        ab_prev = {enc_a, enc_b};
      end
    end
    check("drain_edge_count", edges, 2);
    check("drain_pending_empty", pending, 0);

    // Reset mid-stream with overrun set and a loaded position
    do_reset();
    rate = 32'h7FFF_FFFF; enable = 1'b1;
    t = 0;
    while (!overrun && t < 40) begin tick(); t++; end
    enable = 1'b0; pos_load = 1'b1; pos_value = 32'd1234;
    tick();
    pos_load = 1'b0;
    check("pre_reset_position", position, 1234);
    check("pre_reset_overrun", overrun, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_position", position, 0);
    check("midreset_ab", {enc_a, enc_b}, 0);
    check("midreset_z", enc_z, exp_z(0));
    check("midreset_overrun", overrun, 0);
    check("midreset_pending", pending, 0);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 9) < 8);
      pos_load    = ($urandom_range(0, 49) == 0);
      pos_value   = $urandom_range(0, CPR - 1);
      overrun_clr = ($urandom_range(0, 19) == 0);
      rate        = $urandom >> $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) rate = -rate;
      tick();
    end
    reset = 1'b0; enable = 1'b0; pos_load = 1'b0; overrun_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
